ysyx_23060332_ifu: RTL and testbench

YSYX_23060332_IFU -- requirements
Module: ysyx_23060332_ifu

---
 rtl/ysyx_23060332_ifu.sv | 99 +++++++++
 tb/tb_ysyx_23060332_ifu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding request, 3-cycle best-case fetch loop.
// Optional misalignment trap enabled by defining YSYX_23060332_IFU_ALIGN_CHK_EN.
module ysyx_23060332_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_err_o,
   input  logic        jump_en,
   input  logic [31:0] jump_addr
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic        launch;
   logic [31:0] launch_pc;
   logic        launch_bad;

   // A new fetch starts after reset or when decode takes the held instruction;
   // jump inputs matter only in that handshake cycle.
   always_comb begin
      launch     = (state == IDLE) || ((state == HOLD) && inst_valid_o && inst_ready_i);
      launch_pc  = pc;
      launch_bad = 1'b0;
      if (state == HOLD) begin
         launch_pc = jump_en ? jump_addr : pc + 32'd4;
      end
`ifdef YSYX_23060332_IFU_ALIGN_CHK_EN
      launch_bad = (launch_pc[1:0] != 2'b00);
`else
      launch_bad = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= RESET_PC;
         inst_valid_o  <= 1'b0;
         inst_o        <= NOP;
         inst_addr_o   <= 32'h0;
         inst_err_o    <= 1'b0;
      end else begin
         unique case (state)
            IDLE, HOLD: begin
               if (launch) begin
                  pc <= launch_pc;
                  // A misaligned target is reported as a faulting NOP without touching memory
                  if (launch_bad) begin
                     state        <= HOLD;
                     inst_valid_o <= 1'b1;
                     inst_o       <= NOP;
                     inst_err_o   <= 1'b1;
                     inst_addr_o  <= launch_pc;
                  end else begin
                     state         <= REQ;
                     inst_valid_o  <= 1'b0;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= {launch_pc[31:2], 2'b00};
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  inst_o       <= mem_resp_err ? NOP : mem_resp_data;
                  inst_addr_o  <= pc;
                  inst_err_o   <= mem_resp_err;
                  inst_valid_o <= 1'b1;
                  state        <= HOLD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed self-checking bench for ysyx_23060332_ifu; inputs driven and outputs sampled on the falling edge.
module tb_ysyx_23060332_ifu;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_err_o;
   logic        jump_en;
   logic [31:0] jump_addr;

   int checks;
   int errors;

   ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
      .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
      .inst_addr_o(inst_addr_o), .inst_err_o(inst_err_o),
      .jump_en(jump_en), .jump_addr(jump_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      mem_resp_err = 1'b0; inst_ready_i = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
      tick();
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid got %b want 0", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL rst_req_addr got %h want 80000000", mem_req_addr); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_inst_valid got %b want 0", inst_valid_o); end
      checks++; if (inst_o !== NOP) begin errors++; $display("[TB] FAIL rst_inst got %h want %h", inst_o, NOP); end
      checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst_addr got %h want 0", inst_addr_o); end
      checks++; if (inst_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_inst_err got %b want 0", inst_err_o); end
      rst_n = 1'b1;
      tick();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL first_req got %b/%h want 1/80000000", mem_req_valid, mem_req_addr); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] addr;
      logic [31:0] data;
      inst_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         addr = 32'h8000_0000 + 32'(4 * i);
         data = 32'h0010_0093 + 32'(i << 20);
         checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== addr) begin errors++; $display("[TB] FAIL zw_req%0d got %b/%h want 1/%h", i, mem_req_valid, mem_req_addr, addr); end
         checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL zw_nv_req%0d got %b want 0", i, inst_valid_o); end
         mem_req_ready = 1'b1;
         tick();
         mem_req_ready = 1'b0;
         checks++; if (mem_req_valid !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL zw_wait%0d req/inst valid got %b/%b want 0/0", i, mem_req_valid, inst_valid_o); end
         mem_resp_valid = 1'b1; mem_resp_data = data;
         tick();
         mem_resp_valid = 1'b0;
         checks++; if (inst_valid_o !== 1'b1 || inst_o !== data || inst_addr_o !== addr || inst_err_o !== 1'b0) begin
            errors++; $display("[TB] FAIL zw_hold%0d got v=%b %h @%h e=%b want v=1 %h @%h e=0", i, inst_valid_o, inst_o, inst_addr_o, inst_err_o, data, addr);
         end
         tick();
      end
      inst_ready_i = 1'b0;
   endtask

   task automatic test_stall_and_jump();
      for (int i = 0; i < 3; i++) begin
         checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_000C) begin errors++; $display("[TB] FAIL st_req%0d got %b/%h want 1/8000000c", i, mem_req_valid, mem_req_addr); end
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (mem_req_valid !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL st_wait%0d req/inst valid got %b/%b want 0/0", i, mem_req_valid, inst_valid_o); end
         tick();
      end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h00A0_0513;
      tick();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         jump_en = (i == 1); jump_addr = 32'h1234_0000;
         mem_resp_valid = (i == 2); mem_resp_data = 32'hFFFF_FFFF;
         checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || inst_addr_o !== 32'h8000_000C || mem_req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL st_hold%0d got v=%b %h @%h req=%b want v=1 00a00513 @8000000c req=0", i, inst_valid_o, inst_o, inst_addr_o, mem_req_valid);
         end
         tick();
      end
      mem_resp_valid = 1'b0;
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL st_hold_after got v=%b %h req=%b want v=1 00a00513 req=0", inst_valid_o, inst_o, mem_req_valid); end
      inst_ready_i = 1'b1; jump_en = 1'b1; jump_addr = 32'h8000_0100;
      tick();
      inst_ready_i = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL jump_req got %b/%h v=%b want 1/80000100 v=0", mem_req_valid, mem_req_addr, inst_valid_o); end
   endtask

   task automatic test_bus_error();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
      tick();
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== NOP || inst_err_o !== 1'b1 || inst_addr_o !== 32'h8000_0100) begin
         errors++; $display("[TB] FAIL err_hold got v=%b %h e=%b @%h want v=1 %h e=1 @80000100", inst_valid_o, inst_o, inst_err_o, inst_addr_o, NOP);
      end
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0104) begin errors++; $display("[TB] FAIL err_next got %b/%h want 1/80000104", mem_req_valid, mem_req_addr); end
   endtask

   task automatic test_reset_in_wait();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_0000 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL wrst_req got %b/%h v=%b want 0/80000000 v=0", mem_req_valid, mem_req_addr, inst_valid_o); end
      checks++; if (inst_o !== NOP || inst_addr_o !== 32'h0 || inst_err_o !== 1'b0) begin errors++; $display("[TB] FAIL wrst_inst got %h @%h e=%b want %h @0 e=0", inst_o, inst_addr_o, inst_err_o, NOP); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL wrst_first got %b/%h want 1/80000000", mem_req_valid, mem_req_addr); end
   endtask

   task automatic test_misaligned_jump();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0297;
      tick();
      mem_resp_valid = 1'b0;
      inst_ready_i = 1'b1; jump_en = 1'b1; jump_addr = 32'h8000_0102;
      tick();
      inst_ready_i = 1'b0; jump_en = 1'b0;
`ifdef YSYX_23060332_IFU_ALIGN_CHK_EN
      checks++; if (mem_req_valid !== 1'b0 || inst_valid_o !== 1'b1 || inst_o !== NOP || inst_err_o !== 1'b1 || inst_addr_o !== 32'h8000_0102) begin
         errors++; $display("[TB] FAIL mis_trap got req=%b v=%b %h e=%b @%h want req=0 v=1 %h e=1 @80000102", mem_req_valid, inst_valid_o, inst_o, inst_err_o, inst_addr_o, NOP);
      end
`else
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100) begin errors++; $display("[TB] FAIL mis_req got %b/%h want 1/80000100", mem_req_valid, mem_req_addr); end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0041_0113;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0041_0113 || inst_err_o !== 1'b0 || inst_addr_o !== 32'h8000_0102) begin
         errors++; $display("[TB] FAIL mis_hold got v=%b %h e=%b @%h want v=1 00410113 e=0 @80000102", inst_valid_o, inst_o, inst_err_o, inst_addr_o);
      end
`endif
   endtask

   task automatic test_pc_wrap();
      inst_ready_i = 1'b1; jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
      tick();
      inst_ready_i = 1'b0; jump_en = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_top got %b/%h want 1/fffffffc", mem_req_valid, mem_req_addr); end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0073;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hFFFF_FFFC || inst_o !== 32'h0000_0073) begin errors++; $display("[TB] FAIL wrap_hold got v=%b %h @%h want v=1 00000073 @fffffffc", inst_valid_o, inst_o, inst_addr_o); end
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap_zero got %b/%h want 1/00000000", mem_req_valid, mem_req_addr); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_zero_wait();
      test_stall_and_jump();
      test_bus_error();
      test_reset_in_wait();
      test_misaligned_jump();
      test_pc_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
